// File: rtl/sobel_gcd_pkg.sv
// Shared types and constants for the sobel_gcd GCD job sequencer.
package sobel_gcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } gcd_job_state_e;

    // Command offsets relative to the block's base address.
    localparam logic [7:0] OFF_A_LO   = 8'h00;
    localparam logic [7:0] OFF_A_HI   = 8'h01;
    localparam logic [7:0] OFF_B_LO   = 8'h02;
    localparam logic [7:0] OFF_B_HI   = 8'h03;
    localparam logic [7:0] OFF_START  = 8'h04;
    localparam logic [7:0] OFF_ABORT  = 8'h05;
    localparam logic [7:0] OFF_RES_LO = 8'h08;
    localparam logic [7:0] OFF_RES_HI = 8'h09;
    localparam logic [7:0] OFF_STATUS = 8'h0A;

    // Bit positions inside the status byte.
    localparam int unsigned ST_BUSY = 0;
    localparam int unsigned ST_DONE = 1;
    localparam int unsigned ST_ERR  = 2;
    localparam int unsigned ST_COLL = 3;

endpackage

// File: rtl/gcd_job_ctrl.sv
// Command-driven sequencer for the GCD datapath: operand assembly, launch,
// completion/timeout tracking and register read-back.
module gcd_job_ctrl
    import sobel_gcd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  CMD_BASE       = 8'h20
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    input  logic [15:0] cmd_word_i,
    output logic [15:0] rsp_word_o,
    output logic [15:0] operand_a_o,
    output logic [15:0] operand_b_o,
    output logic        gcd_enable_o,
    input  logic [15:0] gcd_i,
    input  logic        gcd_done_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    gcd_job_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      a_q, a_d;
    logic [15:0]      b_q, b_d;
    logic [15:0]      res_q, res_d;
    logic             coll_q, coll_d;
    logic [15:0]      rsp_q, rsp_d;

    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic [7:0] cmd_off;
    logic       in_range;
    logic       is_run;
    logic       abort_cmd;
    logic [7:0] status;

    assign cmd_addr = cmd_word_i[15:8];
    assign cmd_data = cmd_word_i[7:0];
    // Addresses below the base must not wrap into the map.
    assign in_range = (cmd_addr >= CMD_BASE);
    assign cmd_off  = cmd_addr - CMD_BASE;
    assign is_run   = (state_q == S_RUN);

    assign abort_cmd = cmd_valid_i && in_range && (cmd_off == OFF_ABORT) && cmd_data[0];

    // Status byte assembled from the registered state and sticky collision flag.
    always_comb begin
        status          = 8'h00;
        status[ST_BUSY] = (state_q == S_RUN);
        status[ST_DONE] = (state_q == S_DONE);
        status[ST_ERR]  = (state_q == S_ERR);
        status[ST_COLL] = coll_q;
    end

    // Next-state logic: run completion/timeout first, then the command decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        coll_d  = coll_q;
        rsp_d   = rsp_q;

        // An abort in the same cycle suppresses completion so the result stays put.
        if (is_run) begin
            cnt_d = cnt_q + 1'b1;
            if (!abort_cmd) begin
                if (gcd_done_i) begin
                    res_d   = gcd_i;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end
            end
        end

        if (cmd_valid_i) begin
            if (!in_range) begin
                rsp_d = {cmd_addr, 8'h00};
            end else begin
                case (cmd_off)
                    OFF_A_LO, OFF_A_HI, OFF_B_LO, OFF_B_HI: begin
                        if (is_run) begin
                            coll_d = 1'b1;
                        end else begin
                            // An accepted write invalidates any previous outcome.
                            state_d = S_IDLE;
                            case (cmd_off)
                                OFF_A_LO: a_d[7:0]  = cmd_data;
                                OFF_A_HI: a_d[15:8] = cmd_data;
                                OFF_B_LO: b_d[7:0]  = cmd_data;
                                default:  b_d[15:8] = cmd_data;
                            endcase
                        end
                    end
                    OFF_START: begin
                        if (cmd_data[0]) begin
                            if (is_run) begin
                                coll_d = 1'b1;
                            end else begin
                                cnt_d = '0;
                                // A zero operand makes the GCD trivial; skip the datapath.
                                if ((a_q == 16'h0000) || (b_q == 16'h0000)) begin
                                    res_d   = a_q | b_q;
                                    state_d = S_DONE;
                                end else begin
                                    state_d = S_RUN;
                                end
                            end
                        end
                    end
                    OFF_ABORT: begin
                        if (cmd_data[0]) begin
                            state_d = S_IDLE;
                        end
                    end
                    OFF_RES_LO: rsp_d = {cmd_addr, res_q[7:0]};
                    OFF_RES_HI: rsp_d = {cmd_addr, res_q[15:8]};
                    OFF_STATUS: begin
                        rsp_d  = {cmd_addr, status};
                        coll_d = 1'b0;
                    end
                    default: rsp_d = {cmd_addr, 8'h00};
                endcase
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            res_q   <= 16'h0000;
            coll_q  <= 1'b0;
            rsp_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            coll_q  <= coll_d;
            rsp_q   <= rsp_d;
        end
    end

    assign rsp_word_o   = rsp_q;
    assign operand_a_o  = a_q;
    assign operand_b_o  = b_q;
    assign gcd_enable_o = (state_q == S_RUN);
    assign busy_o       = (state_q == S_RUN);
    assign done_o       = (state_q == S_DONE);
    assign error_o      = (state_q == S_ERR);

endmodule

// File: doc/gcd_job_ctrl.md
Name: gcd_job_ctrl

Overview:
Command-driven sequencer for the GCD datapath in the sobel_gcd design.
- Consumes decoded 16-bit SPI command words: {addr[15:8], data[7:0]}, one per cmd_valid_i pulse, already in clk_i domain.
- Assembles the two 16-bit operands bytewise, launches the GCD unit, and watches for completion with a timeout.
- Captures the result and exposes result/status back to the SPI response path.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles in S_RUN before the job is declared failed; must be ≥ 2.
- CMD_BASE, 8'h20: base command address; all register addresses are CMD_BASE + offset.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  single-cycle strobe; cmd_word_i valid.
- cmd_word_i  in  16  [15:8] address, [7:0] data.
- rsp_word_o  out  16  read response {addr, data}, registered.
- operand_a_o  out  16  GCD operand A.
- operand_b_o  out  16  GCD operand B.
- gcd_enable_o  out  1  held high while the job runs.
- gcd_i  in  16  GCD result.
- gcd_done_i  in  1  GCD completion, sampled only in S_RUN.
- busy_o  out  1  job in progress.
- done_o  out  1  result valid.
- error_o  out  1  timeout occurred.

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - State S_IDLE.
  - All outputs, operand registers, result, counter and sticky bits = 0.
  - Reset mid-job drops gcd_enable_o on the next edge.
- Address map (offsets from CMD_BASE), acting on cmd_valid_i:
  - +0 / +1: A[7:0] / A[15:8].
  - +2 / +3: B[7:0] / B[15:8].
  - +4: START (data[0] = 1).
  - +5: ABORT (data[0] = 1).
  - +8 / +9: read result[7:0] / result[15:8].
  - +A: read status.
  - Unmapped addresses are ignored; rsp_word_o = {addr, 8'h00}.
- Read response:
  - rsp_word_o = {addr, value}, valid one cycle after cmd_valid_i.
  - Holds until the next read.
  - Non-read commands leave rsp_word_o unchanged.
- Status byte: {4'b0, wr_collision, error_o, done_o, busy_o}.
  - Reading status clears wr_collision; the returned value is the pre-clear value.
- Operand writes:
  - Accepted in S_IDLE, S_DONE and S_ERR.
  - Accepted writes clear done_o and error_o.
  - In S_RUN, writes are dropped and set the sticky wr_collision.
- FSM states: S_IDLE, S_RUN, S_DONE, S_ERR.
- START from S_IDLE, S_DONE or S_ERR:
  - Clears done_o, error_o and the counter.
  - If A == 0 or B == 0: result ← A | B, next state S_DONE, gcd_enable_o never asserted. done_o rises 1 cycle after START.
  - Otherwise: next state S_RUN; gcd_enable_o and busy_o go high 1 cycle after START.
- START in S_RUN is ignored and sets wr_collision.
- S_RUN behaviour:
  - Counter increments each cycle.
  - gcd_done_i = 1: result ← gcd_i, then S_DONE.
  - Otherwise, counter == TIMEOUT_CYCLES-1: S_ERR.
  - gcd_done_i and timeout in the same cycle: done wins.
  - ABORT: S_IDLE; result unchanged; done_o and error_o stay 0.
- S_DONE: done_o = 1, busy_o = 0, gcd_enable_o = 0. Remains until START, ABORT or an operand write.
- S_ERR: error_o = 1, gcd_enable_o = 0, result unchanged. Leaves on START, ABORT (to S_IDLE) or an operand write (to S_IDLE).
- ABORT in S_IDLE, S_DONE or S_ERR: go to S_IDLE and clear done_o and error_o.
- Only one command is possible per cycle, so command/command collisions cannot occur.
- Outputs are registered; gcd_enable_o, busy_o, done_o and error_o are all decoded from the registered state.

Decomposition:
- Shared package sobel_gcd_pkg holds:
  - state enum gcd_job_state_e;
  - command offset constants (OFF_A_LO … OFF_STATUS);
  - status bit index constants (ST_BUSY, ST_DONE, ST_ERR, ST_COLL).
- No sub-module.
- The timeout counter is sized $clog2(TIMEOUT_CYCLES) and stays inline.

Test Plan:
1. Write A = 16'd48, B = 16'd18, START; model asserts gcd_done_i with gcd_i = 6 after 10 cycles.
   → gcd_enable_o high 1 cycle after START; done_o = 1; reads of +8 / +9 return 8'h06 / 8'h00; status = 8'h02.
2. A = 16'd0, B = 16'h1234, START → gcd_enable_o stays 0; done_o = 1 the next cycle; result = 16'h1234.
3. TIMEOUT_CYCLES = 16; START with nonzero operands and gcd_done_i never asserted → error_o = 1 exactly 16 cycles after entering S_RUN; gcd_enable_o = 0; status = 8'h04.
4. While in S_RUN: write A_LO = 8'hFF, then START.
   → operand_a_o unchanged; status read = 8'h09.
   → A second status read = 8'h01 (wr_collision cleared).
5. ABORT during S_RUN, then assert gcd_done_i one cycle later → state S_IDLE; done_o = 0; result unchanged; gcd_done_i ignored.
6. Assert rst_i mid-job (S_RUN) → the next cycle has all outputs 0, operands 0 and state S_IDLE.
